fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencer, one-deep inflight tracking and a
// two-entry output FIFO feeding decode, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [8:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        infl_q, kill_q;
    logic [31:0] i0_q, i0_d, p0_q, p0_d;
    logic [31:0] i1_q, i1_d, p1_q, p1_d;
    logic        deq, enq;
    logic [2:0]  occ;

    assign imem_addr = pc_q[10:2];
    assign out_valid = (cnt_q != 2'd0);
    assign out_instr = i0_q;
    assign out_pc    = p0_q;

    always_comb begin
        deq     = out_valid & out_ready;
        occ     = {1'b0, cnt_q} + {2'b00, infl_q};
        imem_en = rst_n & fetch_en & ~redirect_valid
                & (occ < DEPTH + {2'b00, deq});
        // a response landing in a redirect cycle belongs to the old path
        enq     = infl_q & ~kill_q & ~redirect_valid;
        pc_d    = pc_q;
        rpc_d   = imem_en ? pc_q : rpc_q;
        cnt_d   = cnt_q;
        i0_d    = i0_q;
        p0_d    = p0_q;
        i1_d    = i1_q;
        p1_d    = p1_q;
        if (redirect_valid) begin
            cnt_d = 2'd0;
            pc_d  = {redirect_pc[31:2], 2'b00};
        end else begin
            if (imem_en) pc_d = pc_q + 32'd4;
            unique case ({enq, deq})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        i0_d = imem_data;
                        p0_d = rpc_q;
                    end else begin
                        i0_d = i1_q;
                        p0_d = p1_q;
                        i1_d = imem_data;
                        p1_d = rpc_q;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        i0_d = imem_data;
                        p0_d = rpc_q;
                    end else begin
                        i1_d = imem_data;
                        p1_d = rpc_q;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    i0_d  = i1_q;
                    p0_d  = p1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rpc_q  <= 32'd0;
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
            kill_q <= 1'b0;
            i0_q   <= 32'd0;
            p0_q   <= 32'd0;
            i1_q   <= 32'd0;
            p1_q   <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            cnt_q  <= cnt_d;
            infl_q <= imem_en;
            kill_q <= redirect_valid;
            i0_q   <= i0_d;
            p0_q   <= p0_d;
            i1_q   <= i1_d;
            p1_q   <= p1_d;
        end
    end

endmodule
